// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data_mem_v2 memory block and its clear sequencer.
package data_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    // Clear pointer width: enough bits to address DEPTH words, never less than one.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/data_mem_clear_fsm.sv
// Two-state clear sequencer: sweeps word addresses 0..DEPTH-1 after reset or on request.
module data_mem_clear_fsm
    import data_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int PTR_W = ptr_width(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear_req,
    output logic             o_sweep_we,
    output logic [PTR_W-1:0] o_sweep_addr,
    output logic             o_busy
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PTR_W-1:0] r_clr_ptr;
    logic [PTR_W-1:0] w_clr_ptr_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(negedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    // NOTE: defaults first so every path assigns the next-state signals and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        case (r_state)
            CLEAR: begin
                if (r_clr_ptr == LAST) begin
                    w_state_nxt = READY;
                end else begin
                    w_clr_ptr_nxt = r_clr_ptr + 1'b1;
                end
            end
            READY: begin
                if (i_clear_req) begin
                    w_state_nxt   = CLEAR;
                    w_clr_ptr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = CLEAR;
                w_clr_ptr_nxt = '0;
            end
        endcase
    end

    assign o_busy       = (r_state == CLEAR);
    assign o_sweep_we   = (r_state == CLEAR);
    assign o_sweep_addr = r_clr_ptr;

endmodule

// File: rtl/data_mem_v2.sv
// Byte-maskable single-port data memory with registered read, range checking and a clear sweep.
module data_mem_v2
    import data_mem_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter int                DEPTH     = 256,
    parameter int                READ_MODE = READ_FIRST,
    parameter logic [DATA_W-1:0] INIT_VAL  = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   address,
    input  logic                write_enable,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic [DATA_W-1:0]   data_input,
    input  logic                read_enable,
    output logic [DATA_W-1:0]   data_output,
    output logic                read_valid,
    input  logic                clear_req,
    output logic                busy,
    output logic                addr_err
);

    localparam int                NB    = DATA_W / 8;
    localparam int                PTR_W = ptr_width(DEPTH);
    localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_data_output;
    logic              r_read_valid;
    logic              r_addr_err;

    logic              w_sweep_we;
    logic [PTR_W-1:0]  w_sweep_addr;
    logic              w_busy;
    logic              w_in_range;
    logic [PTR_W-1:0]  w_idx;
    logic              w_active;
    logic              w_wr;
    logic              w_rd;
    logic              w_rd_oor;
    logic              w_oor;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;

    data_mem_clear_fsm #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_clear_fsm (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_clear_req  (clear_req),
        .o_sweep_we   (w_sweep_we),
        .o_sweep_addr (w_sweep_addr),
        .o_busy       (w_busy)
    );

    // User accesses are taken only in READY and are dropped on the edge that starts a sweep.
    assign w_in_range = {1'b0, address} < LIMIT;
    assign w_idx      = address[PTR_W-1:0];
    assign w_active   = rst_n && !w_busy && !clear_req;
    assign w_wr       = w_active && write_enable && w_in_range;
    assign w_rd       = w_active && read_enable && w_in_range;
    assign w_rd_oor   = w_active && read_enable && !w_in_range;
    assign w_oor      = w_active && (write_enable || read_enable) && !w_in_range;
    assign w_old      = r_mem[w_idx];

    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < NB; i++) begin
            if (byte_en[i]) begin
                w_merged[8*i +: 8] = data_input[8*i +: 8];
            end
        end
    end

    // NOTE: the array has no reset; its contents are initialised only by the clear sweep.
    always_ff @(negedge clk) begin
        if (rst_n && w_sweep_we) begin
            r_mem[w_sweep_addr] <= INIT_VAL;
        end else if (w_wr) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_data_output <= '0;
            r_read_valid  <= 1'b0;
            r_addr_err    <= 1'b0;
        end else begin
            r_read_valid <= w_rd || w_rd_oor;
            r_addr_err   <= w_oor;
            if (w_rd) begin
                r_data_output <= (READ_MODE == WRITE_FIRST && w_wr) ? w_merged : w_old;
            end else if (w_rd_oor) begin
                r_data_output <= '0;
            end
        end
    end

    assign data_output = r_data_output;
    assign read_valid  = r_read_valid;
    assign addr_err    = r_addr_err;
    assign busy        = w_busy;

endmodule

// File: tb/tb_data_mem_v2.sv
// Scoreboard bench for data_mem_v2: three instances (read-first, write-first, 200-word) share one clock.
module tb_data_mem_v2;
    import data_mem_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NB = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n        [3];
    logic          write_enable [3];
    logic          read_enable  [3];
    logic          clear_req    [3];
    logic [AW-1:0] address      [3];
    logic [NB-1:0] byte_en      [3];
    logic [DW-1:0] data_input   [3];
    logic [DW-1:0] data_output  [3];
    logic          read_valid   [3];
    logic          busy         [3];
    logic          addr_err     [3];

    data_mem_v2 #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16), .READ_MODE(READ_FIRST),
                  .INIT_VAL(32'h5A5A_0F0F)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .address(address[0]), .write_enable(write_enable[0]),
        .byte_en(byte_en[0]), .data_input(data_input[0]), .read_enable(read_enable[0]),
        .data_output(data_output[0]), .read_valid(read_valid[0]), .clear_req(clear_req[0]),
        .busy(busy[0]), .addr_err(addr_err[0]));

    data_mem_v2 #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16), .READ_MODE(WRITE_FIRST),
                  .INIT_VAL(32'h0)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .address(address[1]), .write_enable(write_enable[1]),
        .byte_en(byte_en[1]), .data_input(data_input[1]), .read_enable(read_enable[1]),
        .data_output(data_output[1]), .read_valid(read_valid[1]), .clear_req(clear_req[1]),
        .busy(busy[1]), .addr_err(addr_err[1]));

    data_mem_v2 #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(200), .READ_MODE(READ_FIRST),
                  .INIT_VAL(32'h0)) u_dut2 (
        .clk(clk), .rst_n(rst_n[2]), .address(address[2]), .write_enable(write_enable[2]),
        .byte_en(byte_en[2]), .data_input(data_input[2]), .read_enable(read_enable[2]),
        .data_output(data_output[2]), .read_valid(read_valid[2]), .clear_req(clear_req[2]),
        .busy(busy[2]), .addr_err(addr_err[2]));

    function automatic int dep_of(input int k);
        return (k == 2) ? 200 : 16;
    endfunction

    function automatic logic [DW-1:0] init_of(input int k);
        return (k == 0) ? 32'h5A5A_0F0F : 32'h0;
    endfunction

    function automatic bit wf_of(input int k);
        return (k == 1);
    endfunction

    // Behavioural reference model, one per instance.
    logic [DW-1:0] mem_m [3][256];
    bit            bz_m  [3];
    int            ptr_m [3];
    logic [DW-1:0] do_m  [3];
    bit            rv_m  [3];
    bit            ae_m  [3];

    typedef struct {
        string         tag;
        logic [DW-1:0] dout;
        logic          rv;
        logic          ae;
        logic          bz;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input int j);
        logic [DW-1:0] old_w;
        logic [DW-1:0] mrg;
        bit            inr;
        if (!rst_n[j]) begin
            bz_m[j] = 1; ptr_m[j] = 0; do_m[j] = '0; rv_m[j] = 0; ae_m[j] = 0;
        end else if (bz_m[j]) begin
            mem_m[j][ptr_m[j]] = init_of(j);
            if (ptr_m[j] == dep_of(j) - 1) bz_m[j] = 0;
            else ptr_m[j]++;
            rv_m[j] = 0; ae_m[j] = 0;
        end else if (clear_req[j]) begin
            bz_m[j] = 1; ptr_m[j] = 0; rv_m[j] = 0; ae_m[j] = 0;
        end else begin
            inr   = int'(address[j]) < dep_of(j);
            old_w = mem_m[j][address[j]];
            mrg   = old_w;
            for (int b = 0; b < NB; b++)
                if (byte_en[j][b]) mrg[8*b +: 8] = data_input[j][8*b +: 8];
            if (write_enable[j] && inr) mem_m[j][address[j]] = mrg;
            rv_m[j] = read_enable[j];
            ae_m[j] = (write_enable[j] || read_enable[j]) && !inr;
            if (read_enable[j])
                do_m[j] = !inr ? '0 : (wf_of(j) && write_enable[j]) ? mrg : old_w;
        end
    endtask

    // Advance one falling edge; expectations for instance k are queued first, checked after.
    task automatic tick(input int k, input string tag);
        exp_t e;
        for (int j = 0; j < 3; j++) model_edge(j);
        sb.push_back('{tag: tag, dout: do_m[k], rv: rv_m[k], ae: ae_m[k], bz: bz_m[k]});
        @(negedge clk);
        @(posedge clk);
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".dout"}, data_output[k], e.dout);
            check({e.tag, ".rv"}, {31'd0, read_valid[k]}, {31'd0, e.rv});
            check({e.tag, ".aerr"}, {31'd0, addr_err[k]}, {31'd0, e.ae});
            check({e.tag, ".busy"}, {31'd0, busy[k]}, {31'd0, e.bz});
        end
    endtask

    task automatic op(input int k, input string tag, input logic rst, input logic clr,
                      input logic we, input logic re, input logic [AW-1:0] ad,
                      input logic [NB-1:0] be, input logic [DW-1:0] di);
        for (int j = 0; j < 3; j++) begin
            rst_n[j] = 1'b1; clear_req[j] = 1'b0; write_enable[j] = 1'b0;
            read_enable[j] = 1'b0; address[j] = '0; byte_en[j] = '0; data_input[j] = '0;
        end
        rst_n[k] = rst; clear_req[k] = clr; write_enable[k] = we; read_enable[k] = re;
        address[k] = ad; byte_en[k] = be; data_input[k] = di;
        tick(k, tag);
    endtask

    // Idle until instance k drops busy; the edge count is compared against exp_edges.
    task automatic wait_ready(input int k, input string tag, input int exp_edges);
        int cnt = 0;
        for (int i = 0; i < dep_of(k) + 20; i++) begin
            op(k, tag, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
            cnt++;
            if (busy[k] == 1'b0) break;
        end
        check({tag, ".edges"}, cnt, exp_edges);
    endtask

    initial begin
        for (int j = 0; j < 3; j++) begin
            rst_n[j] = 1'b0; clear_req[j] = 1'b0; write_enable[j] = 1'b0;
            read_enable[j] = 1'b0; address[j] = '0; byte_en[j] = '0; data_input[j] = '0;
        end

        // Reset for two edges, then a full 16-edge sweep.
        tick(0, "rst_a");
        tick(0, "rst_b");
        check("rst_busy", {31'd0, busy[0]}, 32'd1);
        wait_ready(0, "sweep0", 16);
        for (int a = 0; a < 16; a++) begin
            op(0, "rd_init", 1'b1, 1'b0, 1'b0, 1'b1, AW'(a), '0, '0);
            check("rd_init_val", data_output[0], 32'h5A5A_0F0F);
        end

        // Same-address collision in both read modes.
        op(0, "rf_w55", 1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 4'hF, 32'h55);
        op(0, "rf_col", 1'b1, 1'b0, 1'b1, 1'b1, 8'd3, 4'hF, 32'h99);
        check("rf_col_old", data_output[0], 32'h55);
        op(0, "rf_rd", 1'b1, 1'b0, 1'b0, 1'b1, 8'd3, '0, '0);
        check("rf_later", data_output[0], 32'h99);
        op(1, "wf_w55", 1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 4'hF, 32'h55);
        op(1, "wf_col", 1'b1, 1'b0, 1'b1, 1'b1, 8'd3, 4'hF, 32'h99);
        check("wf_col_new", data_output[1], 32'h99);
        op(1, "wf_rd", 1'b1, 1'b0, 1'b0, 1'b1, 8'd3, '0, '0);
        check("wf_later", data_output[1], 32'h99);

        // Byte lanes, including an all-zero mask that must not disturb the word.
        op(1, "bl_full", 1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 4'b1111, 32'hAABB_CCDD);
        op(1, "bl_part", 1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 4'b0101, 32'h1122_3344);
        op(1, "bl_none", 1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 4'b0000, 32'hFFFF_FFFF);
        op(1, "bl_rd", 1'b1, 1'b0, 1'b0, 1'b1, 8'd5, '0, '0);
        check("bl_value", data_output[1], 32'hAA22_CC44);

        // Out-of-range accesses on the 200-word instance.
        wait_ready(2, "sweep2", bz_m[2] ? dep_of(2) - ptr_m[2] : 1);
        op(2, "rg_w0", 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 4'hF, 32'hDEAD_0000);
        op(2, "rg_w199", 1'b1, 1'b0, 1'b1, 1'b0, 8'd199, 4'hF, 32'h0000_BEEF);
        op(2, "rg_rd199", 1'b1, 1'b0, 1'b0, 1'b1, 8'd199, '0, '0);
        op(2, "rg_w210", 1'b1, 1'b0, 1'b1, 1'b0, 8'd210, 4'hF, 32'h7F);
        check("rg_w210_aerr", {31'd0, addr_err[2]}, 32'd1);
        op(2, "rg_rd210", 1'b1, 1'b0, 1'b0, 1'b1, 8'd210, '0, '0);
        check("rg_rd210_aerr", {31'd0, addr_err[2]}, 32'd1);
        check("rg_rd210_dout", data_output[2], 32'd0);
        op(2, "rg_rd200", 1'b1, 1'b0, 1'b0, 1'b1, 8'd200, '0, '0);
        op(2, "rg_idle", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        check("rg_pulse_end", {31'd0, addr_err[2]}, 32'd0);
        for (int a = 0; a < 200; a++)
            op(2, "rg_scan", 1'b1, 1'b0, 1'b0, 1'b1, AW'(a), '0, '0);

        // Clear request with a same-edge access, reset at sweep step 7, writes while busy.
        op(0, "ci_clr", 1'b1, 1'b1, 1'b1, 1'b1, 8'd4, 4'hF, 32'h1234);
        check("ci_busy_rise", {31'd0, busy[0]}, 32'd1);
        for (int s = 0; s < 7; s++)
            op(0, "ci_wbusy", 1'b1, 1'b0, 1'b1, 1'b1, 8'd2, 4'hF, 32'hCAFE_F00D);
        check("ci_step7", ptr_m[0], 7);
        op(0, "ci_rst", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        wait_ready(0, "ci_restart", 16);
        op(0, "ci_rd2", 1'b1, 1'b0, 1'b0, 1'b1, 8'd2, '0, '0);
        check("ci_rd2_init", data_output[0], 32'h5A5A_0F0F);
        op(0, "ci_rd3", 1'b1, 1'b0, 1'b0, 1'b1, 8'd3, '0, '0);
        check("ci_rd3_init", data_output[0], 32'h5A5A_0F0F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/data_mem_v2.md
DATA_MEM_V2 -- requirements
Module: data_mem_v2

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning word width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning address width.
REQ-003 The block SHALL have parameter DEPTH, default 256, meaning implemented words, 1 <= DEPTH <= 2**ADDR_W.
REQ-004 The block SHALL have parameter READ_MODE, default 0, meaning 0 = read-first (old data on same-address collision) and 1 = write-first (new data).
REQ-005 The block SHALL have parameter INIT_VAL, default 0, of width DATA_W, meaning the value written to every word by a clear sweep.
REQ-006 The block SHALL use one clock; reset is synchronous and active-low.
REQ-007 The block SHALL have port clk, input, 1 bit: the clock; all state updates occur on its falling edge.
REQ-008 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset, sampled on the falling edge of clk.
REQ-009 The block SHALL have port address, input, ADDR_W bits: word address for read and write.
REQ-010 The block SHALL have port write_enable, input, 1 bit: write request.
REQ-011 The block SHALL have port byte_en, input, DATA_W/8 bits: per-byte write mask, bit i covering data bits [8i+7:8i].
REQ-012 The block SHALL have port data_input, input, DATA_W bits: write data.
REQ-013 The block SHALL have port read_enable, input, 1 bit: read request.
REQ-014 The block SHALL have port data_output, output, DATA_W bits: registered read data.
REQ-015 The block SHALL have port read_valid, output, 1 bit: data_output was updated by a read at the last edge.
REQ-016 The block SHALL have port clear_req, input, 1 bit: request to start a clear sweep.
REQ-017 The block SHALL have port busy, output, 1 bit: a clear sweep is in progress.
REQ-018 The block SHALL have port addr_err, output, 1 bit: one-cycle pulse for an access with address >= DEPTH.

Function
REQ-019 The control logic SHALL have exactly two states: CLEAR and READY.
REQ-020 In CLEAR, the block SHALL write INIT_VAL to the word at clr_ptr at each edge and increment clr_ptr from 0 to DEPTH-1; at the edge that writes DEPTH-1 it SHALL go to READY, so a sweep takes exactly DEPTH edges.
REQ-021 The busy output SHALL be 1 in CLEAR and 0 in READY.
REQ-022 In CLEAR, write_enable, read_enable and clear_req SHALL be ignored; read_valid and addr_err SHALL stay 0, and data_output SHALL hold its value.
REQ-023 In READY, clear_req=1 at an edge SHALL set clr_ptr to 0 and move the block to CLEAR; any write or read at that same edge SHALL be dropped.
REQ-024 In READY, a write (write_enable=1, address < DEPTH) SHALL update only the bytes whose byte_en bit is 1; byte_en=0 SHALL leave the word unchanged.
REQ-025 In READY, a read (read_enable=1, address < DEPTH) SHALL load data_output at that same edge and set read_valid=1 until the next edge; read-to-data latency is one falling edge.
REQ-026 When no read occurs, data_output SHALL hold its value and read_valid SHALL be 0.
REQ-027 On a same-edge read and write to the same address, data_output SHALL be the pre-write word when READ_MODE=0, or the byte-merged post-write word when READ_MODE=1.
REQ-028 An access with address >= DEPTH SHALL leave memory unchanged, SHALL set data_output to 0 if it is a read (read_valid=1), and SHALL pulse addr_err=1 for one cycle.
REQ-029 clr_ptr SHALL be $clog2(DEPTH) bits wide (minimum 1) and SHALL never wrap past DEPTH-1.

Reset
REQ-030 While rst_n=0 at an edge, the block SHALL enter CLEAR with clr_ptr=0, data_output=0, read_valid=0, addr_err=0 and busy=1.
REQ-031 When rst_n is released, the block SHALL perform a full clear sweep, so busy falls DEPTH edges after the first edge with rst_n=1.
REQ-032 A reset asserted mid-sweep SHALL restart the sweep from address 0.
REQ-033 A reset SHALL NOT itself reset the memory array; the array is cleared only by the sweep.

Structure
REQ-034 A shared package data_mem_pkg SHALL hold the state enum (CLEAR, READY) and the READ_FIRST=0 and WRITE_FIRST=1 constants.
REQ-035 One sub-module, data_mem_clear_fsm, SHALL own the state, clr_ptr and busy, and SHALL output the sweep write strobe and address; the top level SHALL own the array, the port mux and the read register.

Verification
REQ-036 Reset scenario: rst_n low for 2 edges then high, DEPTH=16 -> busy=1 for exactly 16 edges, then reading every address returns INIT_VAL with read_valid=1.
REQ-037 Byte-lane scenario: DATA_W=32, write 0xAABBCCDD to address 5 with byte_en=4'b1111, then write 0x11223344 with byte_en=4'b0101 -> a read of address 5 returns 0xAA22CC44.
REQ-038 Collision scenario: word 3 holds 0x55; at one edge write 0x99 to address 3 with a read of address 3 -> data_output=0x55 for READ_MODE=0 and 0x99 for READ_MODE=1; a later read returns 0x99 in both modes.
REQ-039 Range scenario: DEPTH=200, ADDR_W=8, write 0x7F to address 210 then read address 210 -> addr_err pulses on both edges, data_output=0, and the contents of addresses 0-199 are unchanged.
REQ-040 Clear-interrupt scenario: clear_req pulsed in READY -> busy rises at the next edge; rst_n pulsed low at sweep step 7 -> the sweep restarts and busy stays high for DEPTH more edges after release; write_enable during busy has no effect.
